// File: rtl/buzzer_tone_generator.sv
// Piezo square-wave generator: enforces a minimum beep length, finishes the
// current high phase on a graceful stop, and kills output at once when disabled.
//
// state | meaning
// IDLE  | output low, counters cleared, waiting for ctrl_en && ctrl_buzz
// TONE  | toggling every HALF_PERIOD cycles, minimum-length timer running
// DRAIN | stop accepted, finishing the current high phase before going idle
module buzzer_tone_generator #(
  parameter int CLK_FREQ      = 50000000,
  parameter int TONE_FREQ     = 2000,
  parameter int MIN_ON_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_en,
  input  logic ctrl_buzz,
  output logic buzzer_out,
  output logic busy,
  output logic beep_done
);

  localparam int HALF_PERIOD = CLK_FREQ / (2 * TONE_FREQ);
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int OW = (MIN_ON_CYCLES > 0) ? $clog2(MIN_ON_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [OW-1:0] ON_MAX    = OW'(MIN_ON_CYCLES);
  localparam logic [OW-1:0] ON_FIRST  = OW'(1);

  typedef enum logic [1:0] {IDLE, TONE, DRAIN} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [OW-1:0] on_cnt;

  logic          min_met;
  logic          boundary;
  logic          stop;
  logic          finish;
  logic [HW-1:0] half_next;
  logic [OW-1:0] on_next;

  assign min_met   = (on_cnt == ON_MAX);
  assign boundary  = (half_cnt == HALF_LAST);
  assign stop      = !ctrl_buzz && min_met;
  assign half_next = boundary ? '0 : half_cnt + 1'b1;
  assign on_next   = min_met ? on_cnt : on_cnt + 1'b1;

  // A stop landing on the falling edge of a high phase completes the drain at once.
  assign finish = ((state == TONE) && stop && (!buzzer_out || boundary)) ||
                  ((state == DRAIN) && boundary && buzzer_out);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      buzzer_out <= 1'b0;
      busy       <= 1'b0;
      beep_done  <= 1'b0;
      half_cnt   <= '0;
      on_cnt     <= '0;
    end else begin
      beep_done <= 1'b0;
      unique case (state)
        IDLE: begin
          half_cnt   <= '0;
          on_cnt     <= '0;
          buzzer_out <= 1'b0;
          busy       <= 1'b0;
          if (ctrl_en && ctrl_buzz) begin
            state      <= TONE;
            buzzer_out <= 1'b1;
            busy       <= 1'b1;
            // the entry cycle already counts as time spent in TONE
            on_cnt     <= ON_FIRST;
          end
        end
        TONE, DRAIN: begin
          if (!ctrl_en) begin
            state      <= IDLE;
            buzzer_out <= 1'b0;
            busy       <= 1'b0;
            half_cnt   <= '0;
            on_cnt     <= '0;
          end else if (finish) begin
            state      <= IDLE;
            buzzer_out <= 1'b0;
            busy       <= 1'b0;
            beep_done  <= 1'b1;
            half_cnt   <= '0;
            on_cnt     <= '0;
          end else begin
            half_cnt <= half_next;
            on_cnt   <= on_next;
            if (boundary) buzzer_out <= ~buzzer_out;
            if ((state == TONE) && stop) state <= DRAIN;
            else if ((state == DRAIN) && ctrl_buzz) state <= TONE;
          end
        end
        default: begin
          state      <= IDLE;
          buzzer_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_tone_generator.sv
// Directed bench for buzzer_tone_generator with HALF_PERIOD=5, MIN_ON_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_buzzer_tone_generator;

  logic clk = 1'b0;
  logic rst;
  logic ctrl_en;
  logic ctrl_buzz;
  logic buzzer_out;
  logic busy;
  logic beep_done;

  int n_checks = 0;
  int n_fail   = 0;
  int highs;

  buzzer_tone_generator #(
    .CLK_FREQ(1000),
    .TONE_FREQ(100),
    .MIN_ON_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_en(ctrl_en),
    .ctrl_buzz(ctrl_buzz),
    .buzzer_out(buzzer_out),
    .busy(busy),
    .beep_done(beep_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // k = cycles since the edge that started the beep; phases are 5 high, 5 low
  function automatic logic tone_at(input int k);
    return ((k / 5) % 2) == 0;
  endfunction

  task automatic chk_all(input string tag, input int k, input logic o, input logic b, input logic d);
    chk({tag, "_out"}, k, buzzer_out, o);
    chk({tag, "_busy"}, k, busy, b);
    chk({tag, "_done"}, k, beep_done, d);
  endtask

  initial begin
    rst = 1'b0; ctrl_en = 1'b1; ctrl_buzz = 1'b1;

    // 1. reset held with request asserted
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", i, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    step();
    chk_all("first_high", 0, 1'b1, 1'b1, 1'b0);

    // 2. continuous tone
    for (int k = 1; k < 100; k++) begin
      step();
      chk_all("cont", k, tone_at(k), 1'b1, 1'b0);
    end
    ctrl_en = 1'b0;
    step();
    chk_all("cont_kill", 0, 1'b0, 1'b0, 1'b0);
    ctrl_en = 1'b1; ctrl_buzz = 1'b0;
    step();
    chk_all("idle", 0, 1'b0, 1'b0, 1'b0);

    // 3. one-cycle request gives a minimum-length beep
    ctrl_buzz = 1'b1;
    step();
    chk_all("min", 0, 1'b1, 1'b1, 1'b0);
    ctrl_buzz = 1'b0;
    highs = 0;
    for (int k = 1; k < 20; k++) begin
      step();
      if (buzzer_out && !tone_at(k - 1)) highs++;
      chk_all("min", k, tone_at(k), 1'b1, 1'b0);
    end
    step();
    chk_all("min_end", 20, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("min_after", 21, 1'b0, 1'b0, 1'b0);
    chk("min_pulses", 0, (highs == 1), 1'b1);

    // 4. graceful stop inside a high phase drains it fully
    ctrl_buzz = 1'b1;
    step();
    chk_all("drain", 0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 32; k++) begin
      step();
      chk_all("drain", k, tone_at(k), 1'b1, 1'b0);
    end
    ctrl_buzz = 1'b0;
    for (int k = 32; k < 35; k++) begin
      step();
      chk_all("drain_hold", k, 1'b1, 1'b1, 1'b0);
    end
    step();
    chk_all("drain_end", 35, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("drain_after", 36, 1'b0, 1'b0, 1'b0);

    // 5. hard kill in a high phase
    ctrl_buzz = 1'b1;
    step();
    chk_all("kill", 0, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("kill", 1, 1'b1, 1'b1, 1'b0);
    ctrl_en = 1'b0;
    for (int k = 2; k < 8; k++) begin
      step();
      chk_all("kill_off", k, 1'b0, 1'b0, 1'b0);
    end
    ctrl_en = 1'b1; ctrl_buzz = 1'b0;
    step();
    chk_all("kill_idle", 0, 1'b0, 1'b0, 1'b0);

    // 6. drain aborted by a new request, then graceful stop in a low phase
    ctrl_buzz = 1'b1;
    step();
    chk_all("abort", 0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 32; k++) begin
      step();
      chk_all("abort", k, tone_at(k), 1'b1, 1'b0);
    end
    ctrl_buzz = 1'b0;
    step();
    chk_all("abort_drain", 32, 1'b1, 1'b1, 1'b0);
    ctrl_buzz = 1'b1;
    for (int k = 33; k < 66; k++) begin
      step();
      chk_all("abort_tone", k, tone_at(k), 1'b1, 1'b0);
    end
    ctrl_buzz = 1'b0;
    step();
    chk_all("low_stop", 66, 1'b0, 1'b0, 1'b1);

    // back-to-back beep, then reset mid-beep
    ctrl_buzz = 1'b1;
    step();
    chk_all("b2b", 0, 1'b1, 1'b1, 1'b0);
    step();
    chk_all("b2b", 1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    chk_all("rst_mid", 2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_all("rst_restart", 0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
